// File: rtl/text_writer.sv
// Text-mode character writer: turns a character stream into VRAM writes on a 32-column text grid.
// Optional per-row clearing on each new-row event is enabled by defining TEXT_WRITER_CLEAR_ROW_EN.
package mapache64;
  localparam int unsigned VramAddrWidth = 16;
endpackage

module text_writer #(
  parameter logic [11:0] TXBL_BASE = 12'h900,
  parameter int unsigned ROWS      = 30
) (
  input  logic                               cpu_clk,
  input  logic                               rst_n,
  input  logic [7:0]                         char_data,
  input  logic                               char_valid,
  output logic                               char_ready,
  output logic [mapache64::VramAddrWidth-1:0] vram_address,
  output logic [7:0]                         data_out,
  output logic                               write_enable,
  output logic [4:0]                         cursor_row,
  output logic [4:0]                         cursor_col,
  output logic                               busy
);
  localparam int unsigned AW    = mapache64::VramAddrWidth;
  localparam int unsigned CELLS = 32 * ROWS;
  localparam int unsigned CW    = $clog2(CELLS + 1);

`ifdef TEXT_WRITER_CLEAR_ROW_EN
  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_SCREEN} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR_SCREEN} state_t;
`endif

  state_t          state_q, state_d;
  logic [4:0]      row_q, row_d, col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            accept;
  logic            is_ctrl;
  logic [4:0]      row_next;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [4:0] c);
    return AW'(TXBL_BASE) + AW'({r, c});
  endfunction

  assign char_ready   = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign accept       = char_valid && char_ready;
  assign is_ctrl      = !char_data[7];
  assign row_next     = (row_q == 5'(ROWS - 1)) ? '0 : row_q + 5'd1;
  assign write_enable = we_q;
  assign vram_address = addr_q;
  assign data_out     = data_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= AW'(TXBL_BASE);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // First clearing write is issued from the accepting cycle so the clear
  // states carry a write in every cycle they are occupied.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_ctrl && char_data[6:0] == 7'h08) begin
            if (col_q != '0) begin
              col_d  = col_q - 5'd1;
              we_d   = 1'b1;
              addr_d = cell_addr(row_q, col_q - 5'd1);
              data_d = 8'h20;
            end
          end else if (is_ctrl && char_data[6:0] == 7'h0A) begin
            col_d = '0;
            row_d = row_next;
`ifdef TEXT_WRITER_CLEAR_ROW_EN
            state_d = CLEAR_ROW;
            we_d    = 1'b1;
            addr_d  = cell_addr(row_next, 5'd0);
            data_d  = 8'h20;
            cnt_d   = CW'(1);
`endif
          end else if (is_ctrl && char_data[6:0] == 7'h0C) begin
            state_d = CLEAR_SCREEN;
            row_d   = '0;
            col_d   = '0;
            we_d    = 1'b1;
            addr_d  = AW'(TXBL_BASE);
            data_d  = 8'h20;
            cnt_d   = CW'(1);
          end else begin
            we_d   = 1'b1;
            addr_d = cell_addr(row_q, col_q);
            data_d = char_data;
            if (col_q == 5'd31) begin
              col_d = '0;
              row_d = row_next;
`ifdef TEXT_WRITER_CLEAR_ROW_EN
              state_d = CLEAR_ROW;
              cnt_d   = '0;
`endif
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
      end
`ifdef TEXT_WRITER_CLEAR_ROW_EN
      CLEAR_ROW: begin
        if (cnt_q == CW'(32)) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          addr_d = cell_addr(row_q, cnt_q[4:0]);
          data_d = 8'h20;
          cnt_d  = cnt_q + CW'(1);
        end
      end
`endif
      CLEAR_SCREEN: begin
        if (cnt_q == CW'(CELLS)) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          addr_d = AW'(TXBL_BASE) + AW'(cnt_q);
          data_d = 8'h20;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer in its default build (row clearing disabled).
module tb_text_writer;
  logic                               cpu_clk = 1'b0;
  logic                               rst_n   = 1'b1;
  logic [7:0]                         char_data = '0;
  logic                               char_valid = 1'b0;
  logic                               char_ready;
  logic [mapache64::VramAddrWidth-1:0] vram_address;
  logic [7:0]                         data_out;
  logic                               write_enable;
  logic [4:0]                         cursor_row;
  logic [4:0]                         cursor_col;
  logic                               busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];

  text_writer #(.TXBL_BASE(12'h900), .ROWS(30)) dut (
    .cpu_clk(cpu_clk), .rst_n(rst_n), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .vram_address(vram_address), .data_out(data_out),
    .write_enable(write_enable), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(negedge cpu_clk) begin
    cyc++;
    if (write_enable) begin
      wa.push_back(vram_address);
      wd.push_back(data_out);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cpu_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge cpu_clk);
    char_data  = c;
    char_valid = 1'b1;
    @(posedge cpu_clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    rst_n = 1'b0;
    @(negedge cpu_clk);
    rst_n = 1'b1;
    idle(1);
    clear_log();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_we",   write_enable, 0);
    check("rst_addr", vram_address, 'h900);
    check("rst_data", data_out, 0);
    check("rst_row",  cursor_row, 0);
    check("rst_col",  cursor_col, 0);
    check("rst_busy", busy, 0);
    @(negedge cpu_clk);
    rst_n = 1'b1;
    idle(1);
    clear_log();
    check("rst_ready", char_ready, 1);

    send(8'h41);
    check("A_we",   write_enable, 1);
    check("A_addr", vram_address, 'h900);
    check("A_data", data_out, 'h41);
    check("A_row",  cursor_row, 0);
    check("A_col",  cursor_col, 1);
    idle(1);
    check("A_we_drop", write_enable, 0);

    do_reset();
    repeat (33) send(8'h41);
    idle(1);
    n = wa.size();
    check("b2b_count", n, 33);
    check("b2b_last_addr", (n > 0) ? wa[n-1] : 16'h0, 'h920);
    check("b2b_span", (n > 0) ? wc[n-1] - wc[0] : -1, 32);
    check("b2b_row", cursor_row, 1);
    check("b2b_col", cursor_col, 1);

    do_reset();
    repeat (29) send(8'h0A);
    repeat (31) send(8'h78);
    check("pre_wrap_row", cursor_row, 29);
    check("pre_wrap_col", cursor_col, 31);
    send(8'h42);
    check("wrap_we",   write_enable, 1);
    check("wrap_addr", vram_address, 'hCBF);
    check("wrap_data", data_out, 'h42);
    check("wrap_row",  cursor_row, 0);
    check("wrap_col",  cursor_col, 0);
    check("wrap_ready", char_ready, 1);

    do_reset();
    repeat (3) send(8'h0A);
    clear_log();
    send(8'h08);
    idle(1);
    check("bs0_writes", wa.size(), 0);
    check("bs0_row", cursor_row, 3);
    check("bs0_col", cursor_col, 0);
    repeat (5) send(8'h61);
    send(8'h08);
    check("bs_we",   write_enable, 1);
    check("bs_addr", vram_address, 'h964);
    check("bs_data", data_out, 'h20);
    check("bs_row",  cursor_row, 3);
    check("bs_col",  cursor_col, 4);
    send(8'h8A);
    check("g8A_addr", vram_address, 'h964);
    check("g8A_data", data_out, 'h8A);
    check("g8A_col",  cursor_col, 5);
    idle(1);
    clear_log();
    send(8'h0A);
    idle(1);
    check("nl_writes", wa.size(), 0);
    check("nl_row", cursor_row, 4);
    check("nl_col", cursor_col, 0);
    send(8'h8C);
    check("g8C_addr", vram_address, 'h980);
    check("g8C_data", data_out, 'h8C);
    check("g8C_ready", char_ready, 1);
    idle(1);

    clear_log();
    send(8'h0C);
    check("cls_ready0", char_ready, 0);
    check("cls_busy",   busy, 1);
    check("cls_we",     write_enable, 1);
    for (int i = 0; i < 2000 && !char_ready; i++) idle(1);
    check("cls_done_ready", char_ready, 1);
    n = wa.size();
    check("cls_count", n, 960);
    err = 0;
    for (int i = 0; i < n; i++) begin
      if (wa[i] !== 16'(16'h900 + i) || wd[i] !== 8'h20) err++;
    end
    check("cls_addr_data_errs", err, 0);
    check("cls_span", (n > 0) ? wc[n-1] - wc[0] : -1, 959);
    check("cls_row", cursor_row, 0);
    check("cls_col", cursor_col, 0);
    check("cls_busy_off", busy, 0);

    send(8'h41);
    idle(1);
    clear_log();
    send(8'h0C);
    for (int i = 0; i < 500 && wa.size() < 100; i++) begin
      @(negedge cpu_clk);
      #1;
    end
    rst_n = 1'b0;
    #20;
    @(negedge cpu_clk);
    rst_n = 1'b1;
    idle(10);
    check("abort_writes", wa.size(), 100);
    check("abort_row", cursor_row, 0);
    check("abort_col", cursor_col, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", char_ready, 1);
    check("abort_we", write_enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
